// File: rtl/arinc429_rx_pkg.sv
// Shared definitions for the ARINC 429 receiver: line symbol codes, default
// link timing, word width and receiver FSM states.
package arinc429_rx_pkg;

  localparam int unsigned DefClkHz   = 50_000_000;
  localparam int unsigned DefBitRate = 100_000;
  localparam int unsigned DefGapBits = 4;
  localparam int unsigned WordBits   = 32;

  // Code is simply {A,B} as seen on the line pair.
  typedef enum logic [1:0] {
    SymNull = 2'b00,
    SymLo   = 2'b01,
    SymHi   = 2'b10,
    SymIll  = 2'b11
  } sym_e;

  typedef enum logic [2:0] {
    StGap,
    StIdle,
    StSample,
    StRtz,
    StNext
  } state_e;

  // True for the two symbols that carry a data bit.
  function automatic logic sym_is_bit(input logic [1:0] s);
    return (s == SymHi) || (s == SymLo);
  endfunction

endpackage

// File: rtl/arinc429_line_decode.sv
// Line front end: two-stage synchronizer on A/B followed by symbol decode.
module arinc429_line_decode
  import arinc429_rx_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_line_a,
  input  logic       i_line_b,
  output logic [1:0] o_sym
);

  logic [1:0] r_meta;
  logic [1:0] r_sync;

  // Two-flop synchronizer; reset to NULL so a reset looks like an idle line.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 2'b00;
      r_sync <= 2'b00;
    end else begin
      r_meta <= {i_line_a, i_line_b};
      r_sync <= r_meta;
    end
  end

  // Map the synchronized pair onto the symbol code.
  always_comb begin
    o_sym = SymNull;
    unique case (r_sync)
      2'b10:   o_sym = SymHi;
      2'b01:   o_sym = SymLo;
      2'b11:   o_sym = SymIll;
      default: o_sym = SymNull;
    endcase
  end

endmodule

// File: rtl/arinc429_rx.sv
// ARINC 429 receiver: qualifies the inter-word gap, samples each RZ bit a
// quarter bit after its leading edge, checks framing timing and delivers the
// 32-bit word with an odd-parity flag.
module arinc429_rx
  import arinc429_rx_pkg::*;
#(
  parameter int unsigned CLK_HZ   = DefClkHz,
  parameter int unsigned BIT_RATE = DefBitRate,
  parameter int unsigned GAP_BITS = DefGapBits
) (
  input  logic                F50MHz,
  input  logic                reset,
  input  logic                line_a,
  input  logic                line_b,
  output logic [WordBits-1:0] rx_data,
  output logic                rx_valid,
  output logic                rx_par_err,
  output logic                rx_frame_err,
  output logic                rx_busy
);

  localparam int unsigned T     = CLK_HZ / BIT_RATE;
  localparam int unsigned H     = T / 2;
  localparam int unsigned Q     = T / 4;
  localparam int unsigned TmrW  = $clog2(2 * T);
  localparam int unsigned NullW = $clog2(GAP_BITS * T);

  localparam logic [TmrW-1:0]  TmrQLast    = TmrW'(Q - 1);
  localparam logic [TmrW-1:0]  TmrRtzMax   = TmrW'(H);
  localparam logic [TmrW-1:0]  TmrNextLast = TmrW'(T + H - 1);
  localparam logic [NullW-1:0] NullLast    = NullW'(GAP_BITS * T - 1);
  localparam logic [5:0]       BitLast     = 6'(WordBits - 1);

  logic [1:0]          w_sym;
  state_e              r_state;
  state_e              w_state_nxt;
  logic                w_start;
  logic                w_shift;
  logic                w_abort;
  logic [TmrW-1:0]     r_tmr;
  logic [NullW-1:0]    r_null_cnt;
  logic [5:0]          r_bit_cnt;
  logic [1:0]          r_bit_sym;
  logic [WordBits-1:0] r_shreg;
  logic                r_deliver;
  logic [WordBits-1:0] r_data;
  logic                r_valid;
  logic                r_par_err;
  logic                r_frame_err;

  arinc429_line_decode u_line_decode (
    .i_clk    (F50MHz),
    .i_rst    (reset),
    .i_line_a (line_a),
    .i_line_b (line_b),
    .o_sym    (w_sym)
  );

  // FSM state register.
  always_ff @(posedge F50MHz or posedge reset) begin
    if (reset) r_state <= StGap;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode plus start/shift/abort controls for the datapath.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_shift     = 1'b0;
    w_abort     = 1'b0;
    unique case (r_state)
      StGap: begin
        if (w_sym == SymNull && r_null_cnt == NullLast) w_state_nxt = StIdle;
      end
      StIdle: begin
        // ILL here only disqualifies the gap; it is not a framing error.
        if (w_sym == SymIll) begin
          w_state_nxt = StGap;
        end else if (sym_is_bit(w_sym)) begin
          w_start     = 1'b1;
          w_state_nxt = StSample;
        end
      end
      StSample: begin
        if (w_sym != r_bit_sym) begin
          w_abort = 1'b1;
        end else if (r_tmr == TmrQLast) begin
          w_shift     = 1'b1;
          w_state_nxt = (r_bit_cnt == BitLast) ? StGap : StRtz;
        end
      end
      StRtz: begin
        if (w_sym == SymNull) begin
          w_state_nxt = StNext;
        end else if (w_sym != r_bit_sym || r_tmr >= TmrRtzMax) begin
          w_abort = 1'b1;
        end
      end
      StNext: begin
        if (w_sym == SymIll) begin
          w_abort = 1'b1;
        end else if (sym_is_bit(w_sym)) begin
          w_start     = 1'b1;
          w_state_nxt = StSample;
        end else if (r_tmr >= TmrNextLast) begin
          w_abort = 1'b1;
        end
      end
      default: w_state_nxt = StGap;
    endcase
    if (w_abort) w_state_nxt = StGap;
  end

  // Timers and bit counter; tmr counts cycles since the current bit's leading edge.
  always_ff @(posedge F50MHz or posedge reset) begin
    if (reset) begin
      r_tmr      <= '0;
      r_null_cnt <= '0;
      r_bit_cnt  <= '0;
      r_bit_sym  <= SymNull;
    end else begin
      if (r_state != StGap || w_sym != SymNull) begin
        r_null_cnt <= '0;
      end else if (r_null_cnt != NullLast) begin
        r_null_cnt <= r_null_cnt + 1'b1;
      end

      if (w_start) begin
        // The leading-edge cycle itself is the first cycle of the bit.
        r_tmr     <= TmrW'(1);
        r_bit_sym <= w_sym;
      end else if (r_state == StSample || r_state == StRtz || r_state == StNext) begin
        r_tmr <= r_tmr + 1'b1;
      end

      if (r_state == StIdle && w_start) begin
        r_bit_cnt <= '0;
      end else if (w_shift) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

  // Shift register: first bit on the line ends up in bit 0.
  always_ff @(posedge F50MHz or posedge reset) begin
    if (reset) begin
      r_shreg   <= '0;
      r_deliver <= 1'b0;
    end else begin
      if (w_shift) r_shreg <= {(r_bit_sym == SymHi), r_shreg[WordBits-1:1]};
      r_deliver <= w_shift && (r_bit_cnt == BitLast);
    end
  end

  // Output registers: word and parity load together with the valid strobe.
  always_ff @(posedge F50MHz or posedge reset) begin
    if (reset) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_par_err   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_valid     <= r_deliver;
      r_frame_err <= w_abort;
      if (r_deliver) begin
        r_data    <= r_shreg;
        r_par_err <= ~^r_shreg;
      end
    end
  end

  assign rx_data      = r_data;
  assign rx_valid     = r_valid;
  assign rx_par_err   = r_par_err;
  assign rx_frame_err = r_frame_err;
  assign rx_busy      = (r_state == StSample) || (r_state == StRtz) || (r_state == StNext);

endmodule

// File: tb/tb_arinc429_rx.sv
// Self-checking bench for arinc429_rx: table of words with gap lengths,
// hand-written abort/reset sequences and random words against a gap/parity model.
`timescale 1ns/1ps
module tb_arinc429_rx;

  localparam int unsigned ClkHz   = 50_000_000;
  localparam int unsigned BitRate = 1_250_000;
  localparam int unsigned GapBits = 4;
  localparam int T = ClkHz / BitRate;
  localparam int H = T / 2;
  localparam int Q = T / 4;
  localparam int GapMin = GapBits * T;

  typedef struct {
    logic [31:0] word;
    int          gap;
    bit          exp_valid;
    logic [31:0] exp_data;
    bit          exp_par;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        line_a;
  logic        line_b;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_par_err;
  logic        rx_frame_err;
  logic        rx_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lead_cyc = 0;
  int valid_cnt = 0;
  int ferr_cnt = 0;
  int both_cnt = 0;
  int last_valid_cyc = 0;
  bit busy_seen = 1'b0;

  logic [31:0] model_data;
  bit          model_par;
  vec_t        vecs[7];

  arinc429_rx #(
    .CLK_HZ   (ClkHz),
    .BIT_RATE (BitRate),
    .GAP_BITS (GapBits)
  ) dut (
    .F50MHz       (clk),
    .reset        (reset),
    .line_a       (line_a),
    .line_b       (line_b),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_par_err   (rx_par_err),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt      = valid_cnt + 1;
      last_valid_cyc = cyc;
    end
    if (rx_frame_err) ferr_cnt = ferr_cnt + 1;
    if (rx_valid && rx_frame_err) both_cnt = both_cnt + 1;
    if (rx_busy) busy_seen = 1'b1;
  end

  // Model: a word has a parity error when its count of ones is even.
  function automatic bit par_err_of(input logic [31:0] w);
    int ones = 0;
    for (int k = 0; k < 32; k++) if (w[k]) ones++;
    return (ones % 2) == 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic null_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      line_a = 1'b0;
      line_b = 1'b0;
    end
  endtask

  // Drives nbits bits of w, LSB first; the last bit ends after its symbol half.
  // ill_bit turns that bit to ILL from its 4th cycle; rst_bit pulses reset there.
  task automatic send_word(input logic [31:0] w, input int nbits, input int ill_bit,
                           input int rst_bit);
    for (int i = 0; i < nbits; i++) begin
      int lim;
      lim = (i == nbits - 1) ? H : T;
      for (int c = 0; c < lim; c++) begin
        @(negedge clk);
        if (c == 0) lead_cyc = cyc;
        reset = (i == rst_bit) && (c == 3);
        if (c >= H) begin
          line_a = 1'b0;
          line_b = 1'b0;
        end else if (i == ill_bit && c >= 3) begin
          line_a = 1'b1;
          line_b = 1'b1;
        end else begin
          line_a = w[i];
          line_b = ~w[i];
        end
      end
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int v0;
    int f0;
    null_cycles(v.gap);
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_word(v.word, 32, -1, -1);
    check($sformatf("%s.valid_cnt", name), valid_cnt - v0, {31'd0, v.exp_valid});
    check($sformatf("%s.ferr_cnt", name), ferr_cnt - f0, 32'd0);
    check($sformatf("%s.data", name), rx_data, v.exp_data);
    check($sformatf("%s.par_err", name), {31'd0, rx_par_err}, {31'd0, v.exp_par});
    if (v.exp_valid) begin
      check_range($sformatf("%s.latency", name), last_valid_cyc - lead_cyc, Q + 2, Q + 4);
    end
  endtask

  initial begin
    #1_800_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int v0;
    int f0;
    vec_t v;

    vecs[0] = '{32'h6000_0001, GapMin + 5, 1'b1, 32'h6000_0001, 1'b0};
    vecs[1] = '{32'h0000_0003, GapMin,     1'b1, 32'h0000_0003, 1'b1};
    vecs[2] = '{32'h8000_0000, GapMin,     1'b1, 32'h8000_0000, 1'b0};
    vecs[3] = '{32'h0000_00A1, GapMin,     1'b1, 32'h0000_00A1, 1'b0};
    vecs[4] = '{32'hDEAD_BEEF, GapMin - 1, 1'b0, 32'h0000_00A1, 1'b0};
    vecs[5] = '{32'h1234_5678, 2 * T,      1'b0, 32'h0000_00A1, 1'b0};
    vecs[6] = '{32'hFFFF_FFFF, 5 * T,      1'b1, 32'hFFFF_FFFF, 1'b1};

    reset  = 1'b1;
    line_a = 1'b0;
    line_b = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.data", rx_data, 32'd0);
    check("reset.valid", {31'd0, rx_valid}, 32'd0);
    check("reset.par_err", {31'd0, rx_par_err}, 32'd0);
    check("reset.frame_err", {31'd0, rx_frame_err}, 32'd0);
    check("reset.busy", {31'd0, rx_busy}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), vecs[i]);
    model_data = 32'hFFFF_FFFF;
    model_par  = 1'b1;

    // Word stops after 10 bits: NEXT timeout must abort.
    null_cycles(GapMin);
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_word(32'h0000_03FF, 10, -1, -1);
    null_cycles(2 * T);
    check("trunc.ferr_cnt", ferr_cnt - f0, 32'd1);
    check("trunc.valid_cnt", valid_cnt - v0, 32'd0);
    check("trunc.data", rx_data, model_data);
    check("trunc.busy", {31'd0, rx_busy}, 32'd0);
    v = '{32'h0F0F_1234, GapMin, 1'b1, 32'h0F0F_1234, par_err_of(32'h0F0F_1234)};
    run_vec("after_trunc", v);
    model_data = v.exp_data;
    model_par  = v.exp_par;

    // ILL inside the bit-5 sample window.
    null_cycles(GapMin);
    v0 = valid_cnt;
    f0 = ferr_cnt;
    busy_seen = 1'b0;
    send_word(32'h0000_0015, 6, 5, -1);
    null_cycles(T);
    check("ill.ferr_cnt", ferr_cnt - f0, 32'd1);
    check("ill.valid_cnt", valid_cnt - v0, 32'd0);
    check("ill.busy_seen", {31'd0, busy_seen}, 32'd1);
    check("ill.busy", {31'd0, rx_busy}, 32'd0);
    check("ill.data", rx_data, model_data);
    v = '{32'hA5A5_0001, GapMin, 1'b1, 32'hA5A5_0001, par_err_of(32'hA5A5_0001)};
    run_vec("after_ill", v);

    // Reset pulse in bit 16: word dropped, outputs cleared, next short-gap word ignored.
    null_cycles(GapMin);
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_word(32'h7777_1111, 32, -1, 16);
    check("rst.valid_cnt", valid_cnt - v0, 32'd0);
    check("rst.ferr_cnt", ferr_cnt - f0, 32'd0);
    check("rst.data", rx_data, 32'd0);
    check("rst.par_err", {31'd0, rx_par_err}, 32'd0);
    check("rst.busy", {31'd0, rx_busy}, 32'd0);
    v = '{32'h0000_0007, 2 * T, 1'b0, 32'd0, 1'b0};
    run_vec("rst_short_gap", v);
    v = '{32'h4000_0000, GapMin, 1'b1, 32'h4000_0000, par_err_of(32'h4000_0000)};
    run_vec("rst_recover", v);
    model_data = v.exp_data;
    model_par  = v.exp_par;

    // Random words and gaps against the model: accepted iff the gap is full.
    for (int r = 0; r < 8; r++) begin
      bit long_gap;
      long_gap = ($urandom_range(0, 3) != 0);
      v.word   = $urandom;
      v.gap    = long_gap ? int'($urandom_range(GapMin, GapMin + T))
                          : int'($urandom_range(T, GapMin - 1));
      if (long_gap) begin
        model_data = v.word;
        model_par  = par_err_of(v.word);
      end
      v.exp_valid = long_gap;
      v.exp_data  = model_data;
      v.exp_par   = model_par;
      run_vec($sformatf("rand%0d", r), v);
    end

    null_cycles(T);
    check("valid_ferr_exclusive", both_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
